mesm6_vga_blit: RTL and testbench
=================================

# mesm6_vga_blit

MESM-6 bus initiator that fills a rectangular-free linear span of one VGA bit plane without CPU involvement. It issues the register sequence the 4-plane 320x240 videoadapter expects (address latch, plane select, then a stream of data writes) over the standard MESM-6 rd/wr/done handshake. It sits between a control source (CPU-visible command registers or a boot-time splash loader) and the videoadapter's bus port, and it is the only master on that port while busy.

## Interface
- `VGA_BASE`, 15'o00000: bus address of the videoadapter register window; bits [2:0] are ignored and replaced by the register selector.
- `clk`  in  1  system clock (50 MHz board clock).
- `reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  command strobe, sampled only in IDLE.
- `i_plane`  in  2  plane to fill: 0=Y, 1=R, 2=G, 3=B.
- `i_base`  in  14  first byte address in the plane.
- `i_count`  in  14  number of bytes to write (0..16383).
- `i_fill`  in  8  first fill byte.
- `i_incr`  in  1  1: fill byte increments by 1 after every data write (8-bit wrap); 0: constant.
- `o_busy`  out  1  high from the cycle after an accepted start until the done pulse.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  verify mismatch flag (see Configuration); sticky until next accepted start.
- `o_addr`  out  15  bus address, `{VGA_BASE[14:3], reg}`.
- `o_wr`  out  1  bus write strobe.
- `o_rd`  out  1  bus read strobe.
- `o_wdata`  out  48  write data, zero-extended.
- `i_rdata`  in  48  read data; only [7:0] is used.
- `i_done`  in  1  responder completion.

## Operation
- Register selectors: ADDRL=3'o7, PLANE=3'o6, DATA=3'o0.
- States: IDLE, SET_ADDR, SET_PLANE, WR_DATA, (RB_ADDR, RB_DATA when verify compiled in), FIN.
- IDLE: on `i_start` latch plane, base, count, fill, incr; clear `o_err`; go SET_ADDR. `i_start` in any other state is ignored.
- SET_ADDR: one write of `i_base` to ADDRL. SET_PLANE: one write of `i_plane` to PLANE. WR_DATA: `count` writes of the current fill byte to DATA (responder auto-increments its address latch). Count 0 skips WR_DATA.
- Every transaction is two phases: REQ — strobe and addr/wdata held stable until `i_done`=1; REL — strobe low until `i_done`=0. Next transaction never starts while `i_done` is high.
- Data count decrements once per completed DATA REQ phase; fill byte advances at the same time when `i_incr`=1 (0xFF→0x00).
- FIN: `o_done`=1 for one cycle, `o_busy` drops in that same cycle, return IDLE.
- `o_rd` and `o_wr` are never high together.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_err`=0, `o_wr`=0, `o_rd`=0, `o_addr`={VGA_BASE[14:3],3'o0}, `o_wdata`=0, state IDLE. Reset mid-transfer drops strobes immediately (asynchronous); no further bus cycles.
- All outputs registered. Start sampled in cycle 0 → `o_busy`=1 and `o_wr`=1 (ADDRL) in cycle 1.
- With the videoadapter (done = previous-cycle rd|wr), each transaction takes exactly 4 cycles: strobe c, done c+1, strobe low c+2, done low c+3, next strobe c+4.
- Fill of N bytes without verify: `o_done` in cycle 4·(N+2)+1 after start.
- Slower responders stretch REQ/REL arbitrarily; no timeout.

## Configuration
- `MESM6_VGA_BLIT_VERIFY_EN` defined: after WR_DATA, RB_ADDR rewrites `i_base` to ADDRL, then RB_DATA issues `count` reads of DATA; each `i_rdata[7:0]` is compared with the regenerated expected byte (same fill/incr sequence); any mismatch sets `o_err`. Adds 4·(N+1) cycles.
- Not defined: RB states absent, `o_rd` tied 0, `o_err` tied 0.

## Test plan
- Reset mid-transfer: start N=100, assert `reset` during the 10th data write → `o_wr`/`o_busy` low in the same cycle, no `o_done`; after release a new start runs cleanly.
- Constant fill: plane=1, base=0x0010, count=4, fill=0xA5 against the videoadapter model → writes ADDRL=0x0010, PLANE=1, then 4×0xA5 to R plane bytes 0x10..0x13; `o_done` at cycle 25.
- Increment with wrap: count=3, fill=0xFE, incr=1 → data 0xFE, 0xFF, 0x00.
- Count 0: base=0x1234, count=0 → exactly two writes (ADDRL, PLANE), `o_done` at cycle 9; start asserted while busy is ignored.
- Stretched handshake: responder holds `i_done` low 5 cycles per REQ and high 3 cycles per REL → strobe/addr/wdata stable throughout, no dropped or duplicated writes.
- Verify (macro on): fill 8 bytes 0x3C, model corrupts byte 5 → `o_err`=1 at `o_done`; uncorrupted run → `o_err`=0.

Source files
------------

// File: rtl/mesm6_vga_blit_if.sv
// mesm6_vga_blit_if: MESM-6 bus port between the blitter (master) and the videoadapter (slave)
// addr/wr/rd/wdata flow master->slave, rdata/done flow slave->master.
interface mesm6_vga_blit_if;
  logic [14:0] addr;
  logic        wr;
  logic        rd;
  logic [47:0] wdata;
  logic [47:0] rdata;
  logic        done;
  modport master (output addr, wr, rd, wdata, input rdata, done);
  modport slave (input addr, wr, rd, wdata, output rdata, done);
endinterface

// File: rtl/mesm6_vga_blit.sv
// mesm6_vga_blit: MESM-6 bus initiator filling a linear span of one VGA bit plane
// Ports: clk, reset (async, active-high); command i_start/i_plane/i_base/i_count/i_fill/i_incr;
// status o_busy/o_done/o_err; bus = videoadapter port (master modport).
// Optional read-back verify: define MESM6_VGA_BLIT_VERIFY_EN.
module mesm6_vga_blit #(
  parameter logic [14:0] VGA_BASE = 15'o00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_plane,
  input  logic [13:0] i_base,
  input  logic [13:0] i_count,
  input  logic [7:0]  i_fill,
  input  logic        i_incr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  mesm6_vga_blit_if.master bus
);
`ifdef MESM6_VGA_BLIT_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SET_ADDR, SET_PLANE, WR_DATA, RB_ADDR, RB_DATA, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, SET_ADDR, SET_PLANE, WR_DATA, FIN} state_t;
`endif
  state_t state_q, state_d;
  logic rel_q, rel_d, busy_q, busy_d, done_q, done_d, wr_q, wr_d, incr_q, incr_d;
  logic [14:0] addr_q, addr_d;
  logic [47:0] wdata_q, wdata_d;
  logic [1:0] plane_q, plane_d;
  logic [13:0] cnt_q, cnt_d;
  logic [7:0] fill_q, fill_d;
  logic last, data_st, unused_rdata;
  assign last = cnt_q == 14'd0;
  assign unused_rdata = ^bus.rdata;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
  logic rd_q, rd_d, err_q, err_d;
  logic [13:0] base_q, base_d, cnt0_q, cnt0_d;
  logic [7:0] fill0_q, fill0_d;
  assign data_st = state_q == WR_DATA || state_q == RB_DATA;
  assign bus.rd = rd_q;
  assign o_err = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q <= 1'b0;
      err_q <= 1'b0;
      base_q <= '0;
      cnt0_q <= '0;
      fill0_q <= '0;
    end else begin
      rd_q <= rd_d;
      err_q <= err_d;
      base_q <= base_d;
      cnt0_q <= cnt0_d;
      fill0_q <= fill0_d;
    end
`else
  assign data_st = state_q == WR_DATA;
  assign bus.rd = 1'b0;
  assign o_err = 1'b0;
`endif
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign bus.wr = wr_q;
  assign bus.addr = addr_q;
  assign bus.wdata = wdata_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rel_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= {VGA_BASE[14:3], 3'o0};
      wdata_q <= '0;
      plane_q <= '0;
      cnt_q <= '0;
      fill_q <= '0;
      incr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q <= rel_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      plane_q <= plane_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      incr_q <= incr_d;
    end
  always_comb begin
    state_d = state_q;
    rel_d = rel_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    plane_d = plane_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    incr_d = incr_q;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
    rd_d = rd_q;
    err_d = err_q;
    base_d = base_q;
    cnt0_d = cnt0_q;
    fill0_d = fill0_q;
`endif
    if (state_q == IDLE) begin
      if (i_start) begin
        state_d = SET_ADDR;
        rel_d = 1'b0;
        busy_d = 1'b1;
        wr_d = 1'b1;
        addr_d = {VGA_BASE[14:3], 3'o7};
        wdata_d = {34'd0, i_base};
        plane_d = i_plane;
        cnt_d = i_count;
        fill_d = i_fill;
        incr_d = i_incr;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
        err_d = 1'b0;
        base_d = i_base;
        cnt0_d = i_count;
        fill0_d = i_fill;
`endif
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end else if (!rel_q) begin
      if (bus.done) begin
        rel_d = 1'b1;
        wr_d = 1'b0;
        cnt_d = data_st ? cnt_q - 14'd1 : cnt_q;
        fill_d = data_st ? fill_q + {7'd0, incr_q} : fill_q;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
        rd_d = 1'b0;
        err_d = err_q | (state_q == RB_DATA && bus.rdata[7:0] != fill_q);
`endif
      end
    end else if (!bus.done) begin
      rel_d = 1'b0;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
      state_d = state_q == SET_ADDR ? SET_PLANE :
                (state_q == RB_ADDR || state_q == RB_DATA) ? (last ? FIN : RB_DATA) :
                last ? RB_ADDR : WR_DATA;
      // read-back regenerates the fill sequence from the latched start values
      cnt_d = state_d == RB_ADDR ? cnt0_q : cnt_q;
      fill_d = state_d == RB_ADDR ? fill0_q : fill_q;
      rd_d = state_d == RB_DATA;
      wr_d = state_d != FIN && state_d != RB_DATA;
      addr_d = {VGA_BASE[14:3], state_d == SET_PLANE ? 3'o6 : state_d == RB_ADDR ? 3'o7 : 3'o0};
      wdata_d = state_d == SET_PLANE ? {46'd0, plane_q} :
                state_d == RB_ADDR ? {34'd0, base_q} : {40'd0, fill_q};
`else
      state_d = state_q == SET_ADDR ? SET_PLANE : last ? FIN : WR_DATA;
      wr_d = state_d != FIN;
      addr_d = {VGA_BASE[14:3], state_d == SET_PLANE ? 3'o6 : 3'o0};
      wdata_d = state_d == SET_PLANE ? {46'd0, plane_q} : {40'd0, fill_q};
`endif
      busy_d = state_d != FIN;
      done_d = state_d == FIN;
    end
  end
endmodule

// File: tb/tb_mesm6_vga_blit.sv
// tb_mesm6_vga_blit: randomized self-checking bench with a videoadapter responder and transaction-list model
module tb_mesm6_vga_blit;
`ifdef MESM6_VGA_BLIT_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam logic [14:0] A_ADDRL = 15'o7, A_PLANE = 15'o6, A_DATA = 15'o0;
  typedef struct packed {logic rd; logic [14:0] addr; logic [47:0] data;} txn_t;
  logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_incr = 1'b0;
  logic [1:0] i_plane = '0;
  logic [13:0] i_base = '0, i_count = '0;
  logic [7:0] i_fill = '0;
  logic o_busy, o_done, o_err;
  mesm6_vga_blit_if bus();
  mesm6_vga_blit dut (.clk(clk), .reset(reset), .i_start(i_start), .i_plane(i_plane), .i_base(i_base),
    .i_count(i_count), .i_fill(i_fill), .i_incr(i_incr), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic txn_t mk(input logic rd, input logic [14:0] a, input logic [47:0] d);
    return {rd, a, d};
  endfunction
  txn_t log_q[$];
  txn_t cur;
  logic [7:0] mem [4][16384];
  logic [13:0] latch;
  logic [1:0] pl;
  int reqd = 1, reld = 1, corrupt = -1;
  int rphase, rcnt, rreads, unstable = 0, both_hi = 0, ndone = 0;
  always @(posedge clk) if (o_done) ndone <= ndone + 1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.done <= 1'b0;
      bus.rdata <= '0;
      rphase <= 0;
      rcnt <= 0;
    end else begin
      if (bus.wr && bus.rd) both_hi <= both_hi + 1;
      if (rphase == 0) begin
        if (bus.wr || bus.rd) begin
          if (rcnt == 0) begin
            cur = mk(bus.rd, bus.addr, bus.rd ? 48'd0 : bus.wdata);
            log_q.push_back(cur);
            if (bus.wr && bus.addr[2:0] == 3'o7) begin
              latch <= bus.wdata[13:0];
              rreads <= 0;
            end else if (bus.wr && bus.addr[2:0] == 3'o6) pl <= bus.wdata[1:0];
            else if (bus.wr && bus.addr[2:0] == 3'o0) begin
              mem[pl][latch] <= bus.wdata[7:0];
              latch <= latch + 14'd1;
            end else if (bus.rd) begin
              bus.rdata <= {40'd0, mem[pl][latch] ^ ((rreads == corrupt) ? 8'hFF : 8'h00)};
              rreads <= rreads + 1;
              latch <= latch + 14'd1;
            end
          end else if (mk(bus.rd, bus.addr, bus.rd ? 48'd0 : bus.wdata) != cur) unstable <= unstable + 1;
          if (rcnt == reqd - 1) begin
            bus.done <= 1'b1;
            rphase <= 1;
            rcnt <= 0;
          end else rcnt <= rcnt + 1;
        end
      end else if (!bus.wr && !bus.rd) begin
        if (rcnt == reld - 1) begin
          bus.done <= 1'b0;
          rphase <= 0;
          rcnt <= 0;
        end else rcnt <= rcnt + 1;
      end
    end
  end
  task automatic run(input int plane, input int base, input int count, input int fill, input int incr,
                     input int rq, input int rl, input int cor, input string tag);
    txn_t e[$];
    int t, per, nexp;
    reqd = rq;
    reld = rl;
    corrupt = cor;
    per = rq + rl + 2;
    e.push_back(mk(1'b0, A_ADDRL, 48'(base)));
    e.push_back(mk(1'b0, A_PLANE, 48'(plane)));
    for (int i = 0; i < count; i++) e.push_back(mk(1'b0, A_DATA, 48'((fill + i * incr) % 256)));
    for (int i = 0; i < VER * (count + 1); i++) e.push_back(mk(i != 0, i == 0 ? A_ADDRL : A_DATA, i == 0 ? 48'(base) : 48'd0));
    log_q.delete();
    @(negedge clk);
    i_plane = 2'(plane);
    i_base = 14'(base);
    i_count = 14'(count);
    i_fill = 8'(fill);
    i_incr = 1'(incr);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    {i_plane, i_base, i_count, i_fill, i_incr} = 39'($urandom);
    check({tag, ".start"}, {o_busy, bus.wr, bus.rd, bus.addr}, {3'b110, A_ADDRL});
    t = 1;
    while (!o_done && t < 20000) begin
      i_start = t == 6;
      @(posedge clk);
      #1;
      t++;
    end
    i_start = 1'b0;
    check({tag, ".lat"}, t, per * (count + 2) + 1 + VER * per * (count + 1));
    check({tag, ".fin"}, {o_busy, o_done, o_err}, {2'b01, 1'(VER == 1 && cor >= 0 && cor < count)});
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, {o_busy, o_done}, 2'b00);
    nexp = e.size();
    check({tag, ".n"}, log_q.size(), nexp);
    for (int i = 0; i < nexp && i < log_q.size(); i++) check({tag, ".txn"}, log_q[i], e[i]);
  endtask
  initial begin
    int nd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", {o_busy, o_done, o_err, bus.wr, bus.rd}, 5'b0);
    check("rst.addr", bus.addr, A_DATA);
    check("rst.wdata", bus.wdata, 48'd0);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    nd0 = ndone;
    @(negedge clk);
    {i_plane, i_base, i_count, i_fill, i_incr} = {2'd2, 14'd0, 14'd100, 8'h11, 1'b1};
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.wr && rphase == 0 && rcnt == 0 && log_q.size() == 11) break;
      @(posedge clk);
      #1;
    end
    check("rst.reach", log_q.size(), 11);
    reset = 1'b1;
    #1;
    check("rst.mid", {bus.wr, o_busy, o_done}, 3'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.nodone", ndone - nd0, 0);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    repeat (8) @(posedge clk);
    #1;
    check("rst.quiet", log_q.size(), 0);
    run(1, 'h0010, 4, 'hA5, 0, 1, 1, -1, "const");
    run(2, 'h2000, 3, 'hFE, 1, 1, 1, -1, "wrap");
    run(0, 'h1234, 0, 'h00, 0, 1, 1, -1, "zero");
    run(3, 'h0100, 6, 'h5A, 1, 5, 3, -1, "stretch");
    run(1, 'h0020, 8, 'h3C, 0, 1, 1, 5, "vfy_bad");
    run(1, 'h0020, 8, 'h3C, 0, 1, 1, -1, "vfy_ok");
    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 3), $urandom_range(0, 16383), $urandom_range(0, 12), $urandom_range(0, 255),
          $urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(1, 4),
          $urandom_range(0, 1) ? int'($urandom_range(0, 12)) : -1, "rand");
    check("stable", unstable, 0);
    check("rdwr_excl", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
